// File: rtl/program_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// State encoding, byte/instruction widths and a small state-decode helper.
package program_loader_pkg;

  localparam int INST_W = 16;
  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    S_HDR,
    S_HI,
    S_LO,
    S_WR,
    S_CK,
    S_DONE,
    S_ERR
  } state_e;

  // States in which the loader is willing to take a byte from the stream
  function automatic logic accepts_byte(state_e s);
    return (s == S_HDR) || (s == S_HI) || (s == S_LO) || (s == S_CK);
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// master = stream source / memory side, slave = the loader itself.
interface program_loader_if
  import program_loader_pkg::*;
#(
  parameter int ADDR_W = 8
);

  logic [BYTE_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [INST_W-1:0] imem_wdata;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, imem_we, imem_addr, imem_wdata
  );

endinterface

// File: rtl/program_loader_checksum.sv
// 8-bit XOR accumulator over the load stream.
// clear and enable together load the incoming byte (start of a new load).
module program_loader_checksum
  import program_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              enable,
  input  logic [BYTE_W-1:0] din,
  output logic [BYTE_W-1:0] acc
);

  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
    end else if (clear || enable) begin
      acc <= (clear ? '0 : acc) ^ (enable ? din : '0);
    end
  end

endmodule

// File: rtl/program_loader.sv
// Boot loader: packs stream byte pairs into instruction words, writes them from
// address 0 upward, verifies an XOR checksum and releases core reset on success.
//
//  state | meaning
//  HDR   | waiting for word-count header byte
//  HI    | waiting for high byte of next word
//  LO    | waiting for low byte of next word
//  WR    | one-cycle instruction-memory write, no byte taken
//  CK    | waiting for checksum byte
//  DONE  | load good, core released
//  ERR   | checksum mismatch, core held in reset
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter bit CHECKSUM_EN = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            reload,
  program_loader_if.slave bus,
  output logic            core_reset,
  output logic            load_done,
  output logic            load_error,
  output logic [ADDR_W:0] words_loaded
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] n_q, addr_q;
  logic [BYTE_W-1:0] hi_q, lo_q, csum;
  logic [ADDR_W:0]   words_q, words_inc, words_target;
  logic              accept, csum_clear, csum_en;

  assign accept       = bus.rx_valid & bus.rx_ready;
  assign words_inc    = words_q + (ADDR_W+1)'(1);
  // A header of 0 encodes a full memory: the extra MSB makes it 2**ADDR_W
  assign words_target = {(n_q == '0), n_q};
  assign csum_clear   = accept & ~reload & (state_q == S_HDR);
  assign csum_en      = accept & ~reload &
                        ((state_q == S_HDR) || (state_q == S_HI) || (state_q == S_LO));

  program_loader_checksum u_csum (
    .clk    (clk),
    .reset  (reset),
    .clear  (csum_clear),
    .enable (csum_en),
    .din    (bus.rx_data),
    .acc    (csum)
  );

  assign bus.rx_ready   = accepts_byte(state_q);
  assign bus.imem_we    = (state_q == S_WR);
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = {hi_q, lo_q};
  assign words_loaded   = words_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_HDR: if (accept) state_d = S_HI;
      S_HI:  if (accept) state_d = S_LO;
      S_LO:  if (accept) state_d = S_WR;
      S_WR: begin
        if (words_inc == words_target) state_d = CHECKSUM_EN ? S_CK : S_DONE;
        else                           state_d = S_HI;
      end
      S_CK:  if (accept) state_d = (bus.rx_data == csum) ? S_DONE : S_ERR;
      default: ;
    endcase
    if (reload) state_d = S_HDR;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_HDR;
      n_q        <= '0;
      addr_q     <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      words_q    <= '0;
      core_reset <= 1'b1;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      state_q    <= state_d;
      // Flags follow the next state so they change on the same edge as the FSM
      core_reset <= (state_d != S_DONE);
      load_done  <= (state_d == S_DONE);
      load_error <= (state_d == S_ERR);
      if (reload) begin
        addr_q  <= '0;
        words_q <= '0;
      end else begin
        unique case (state_q)
          S_HDR: if (accept) begin
            n_q     <= ADDR_W'(bus.rx_data);
            addr_q  <= '0;
            words_q <= '0;
          end
          S_HI: if (accept) hi_q <= bus.rx_data;
          S_LO: if (accept) lo_q <= bus.rx_data;
          S_WR: begin
            words_q <= words_inc;
            addr_q  <= addr_q + ADDR_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed plus randomized bench for program_loader; expected writes and flags
// come from a stream-level model of header, byte pairs and XOR checksum.
module tb_program_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       reload;
  logic       core_reset, load_done, load_error;
  logic [8:0] words_loaded;

  program_loader_if #(.ADDR_W(8)) bus ();

  program_loader #(.ADDR_W(8), .CHECKSUM_EN(1'b1)) dut (
    .clk          (clk),
    .reset        (reset),
    .reload       (reload),
    .bus          (bus),
    .core_reset   (core_reset),
    .load_done    (load_done),
    .load_error   (load_error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Write observer: every strobe cycle is recorded, back-to-back strobes counted
  logic [23:0] wr_q[$];
  int          we_double = 0;
  logic        prev_we   = 1'b0;
  always @(negedge clk) begin
    if (bus.imem_we) begin
      wr_q.push_back({bus.imem_addr, bus.imem_wdata});
      if (prev_we) we_double++;
    end
    prev_we = bus.imem_we;
  end

  logic [7:0] stim[$];
  int         wr_start;
  int         dbl_start;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (!bus.rx_ready && n < 200) begin
      tick(1);
      n++;
    end
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL send_timeout: observed rx_ready=0 expected rx_ready=1");
    end
    tick(1);
    bus.rx_valid = 1'b0;
    if (gap > 0) tick(gap);
  endtask

  // gapmode 0/1: fixed idle cycles after each byte; 2: random 0..2
  task automatic run_stream(input int gapmode);
    wr_start  = wr_q.size();
    dbl_start = we_double;
    foreach (stim[i]) send_byte(stim[i], (gapmode == 2) ? int'($urandom_range(0, 2)) : gapmode);
  endtask

  task automatic check_load(input string tag);
    int         n;
    int         w = 0;
    logic [7:0] x = 8'h00;
    logic       ok;
    n = (stim[0] == 8'h00) ? 256 : int'(stim[0]);
    for (int i = 0; i <= 2 * n; i++) x ^= stim[i];
    ok = (x == stim[2 * n + 1]);
    while (!(load_done || load_error) && w < 20) begin
      tick(1);
      w++;
    end
    check({tag, "_done"}, load_done, ok);
    check({tag, "_error"}, load_error, !ok);
    check({tag, "_core_reset"}, core_reset, !ok);
    check({tag, "_rx_ready"}, bus.rx_ready, 1'b0);
    check({tag, "_words"}, words_loaded, n);
    check({tag, "_nwrites"}, wr_q.size() - wr_start, n);
    check({tag, "_double"}, we_double - dbl_start, 0);
    for (int i = 0; i < n && (wr_start + i) < wr_q.size(); i++)
      check({tag, "_wr"}, wr_q[wr_start + i], {8'(i), stim[1 + 2 * i], stim[2 + 2 * i]});
  endtask

  task automatic do_reload(input string tag);
    reload = 1'b1;
    tick(1);
    reload = 1'b0;
    check({tag, "_rl_ready"}, bus.rx_ready, 1'b1);
    check({tag, "_rl_core_reset"}, core_reset, 1'b1);
    check({tag, "_rl_done"}, load_done, 1'b0);
    check({tag, "_rl_error"}, load_error, 1'b0);
    check({tag, "_rl_words"}, words_loaded, 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, bus.rx_ready, 1'b1);
    check({tag, "_we"}, bus.imem_we, 1'b0);
    check({tag, "_addr"}, bus.imem_addr, 0);
    check({tag, "_wdata"}, bus.imem_wdata, 0);
    check({tag, "_core_reset"}, core_reset, 1'b1);
    check({tag, "_done"}, load_done, 1'b0);
    check({tag, "_error"}, load_error, 1'b0);
    check({tag, "_words"}, words_loaded, 0);
  endtask

  task automatic make_random(input int n, input logic good);
    logic [7:0] x;
    stim.delete();
    stim.push_back(8'(n));
    x = 8'(n);
    for (int i = 0; i < 2 * ((n == 0) ? 256 : n); i++) begin
      stim.push_back(8'($urandom));
      x ^= stim[stim.size() - 1];
    end
    stim.push_back(good ? x : (x ^ 8'($urandom_range(1, 255))));
  endtask

  initial begin
    reset        = 1'b1;
    reload       = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    tick(3);
    reset = 1'b0;
    check_reset_values("por");

    // Basic two-word load, including write and release latency
    stim = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
    wr_start  = wr_q.size();
    dbl_start = we_double;
    send_byte(8'h02, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    check("t1_we", bus.imem_we, 1'b1);
    check("t1_addr", bus.imem_addr, 0);
    check("t1_wdata", bus.imem_wdata, 16'h1234);
    check("t1_ready_wr", bus.rx_ready, 1'b0);
    send_byte(8'hAB, 0);
    send_byte(8'hCD, 0);
    send_byte(8'h42, 0);
    check("t1_done_latency", load_done, 1'b1);
    check("t1_core_latency", core_reset, 1'b0);
    check_load("t1");

    // Same payload with a bad checksum
    do_reload("t2");
    stim = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
    run_stream(0);
    check_load("t2");
    tick(3);
    check("t2_core_held", core_reset, 1'b1);

    // Stream with rx_valid toggling every cycle
    do_reload("t3");
    stim = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
    run_stream(1);
    check_load("t3");

    // Reload mid-load, with a byte offered in the same cycle, then a full load
    do_reload("t4a");
    send_byte(8'h02, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    tick(1);
    bus.rx_data  = 8'h05;
    bus.rx_valid = 1'b1;
    do_reload("t4b");
    bus.rx_valid = 1'b0;
    stim = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
    run_stream(0);
    check_load("t4");

    // Full-capacity load: header 0 means 256 words
    do_reload("t5");
    make_random(0, 1'b1);
    run_stream(0);
    check_load("t5");
    tick(5);
    check("t5_no_extra_wr", wr_q.size() - wr_start, 256);

    // Randomized loads, gaps and checksum corruption
    for (int k = 0; k < 8; k++) begin
      do_reload("rnd");
      make_random(int'($urandom_range(1, 20)), 1'($urandom_range(0, 1)));
      run_stream(2);
      check_load("rnd");
    end

    // Synchronous reset landing in the write cycle
    do_reload("t6");
    send_byte(8'h01, 0);
    send_byte(8'hEE, 0);
    send_byte(8'h77, 0);
    check("t6_in_wr", bus.imem_we, 1'b1);
    reset = 1'b1;
    tick(1);
    check_reset_values("t6_rst");
    reset = 1'b0;
    tick(1);
    check_reset_values("t6_after");

    // Reload from DONE puts the core back into reset next cycle
    stim = '{8'h01, 8'h5A, 8'hA5, 8'hFE};
    run_stream(0);
    check_load("t6b");
    do_reload("t6c");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
